// File: rtl/atm_pkg.sv
// Shared constants, op/state codes and the default PIN table for the ATM controller.
package atm_pkg;

  localparam int NUM_ACCOUNTS = 10;
  localparam int INIT_BALANCE = 1000;
  localparam int DATA_W       = 16;

  localparam logic [2:0] OP_NOP        = 3'd0;
  localparam logic [2:0] OP_WITHDRAW   = 3'd1;
  localparam logic [2:0] OP_CHANGE_PIN = 3'd2;
  localparam logic [2:0] OP_BALANCE    = 3'd3;
  localparam logic [2:0] OP_EXIT       = 3'd4;
  localparam logic [2:0] OP_DEPOSIT    = 3'd5;

  // State codes mirror the op code that produced them.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WITHDRAW   = 3'd1,
    ST_CHANGE_PIN = 3'd2,
    ST_BALANCE    = 3'd3,
    ST_EXIT       = 3'd4,
    ST_DEPOSIT    = 3'd5,
    ST_ERROR      = 3'd7
  } atm_state_t;

  function automatic logic [DATA_W-1:0] default_pin(input int idx);
    case (idx)
      1:       default_pin = 16'd1234;
      2:       default_pin = 16'd2345;
      3:       default_pin = 16'd3456;
      4:       default_pin = 16'd4567;
      5:       default_pin = 16'd5678;
      6:       default_pin = 16'd6789;
      7:       default_pin = 16'd7890;
      8:       default_pin = 16'd8901;
      9:       default_pin = 16'd9012;
      10:      default_pin = 16'd7123;
      default: default_pin = '0;
    endcase
  endfunction

endpackage

// File: rtl/atm_account_bank.sv
// PIN and balance storage for accounts 1..NUM_ACCOUNTS: combinational read, one write port.
module atm_account_bank
  import atm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        rd_addr,
  output logic [DATA_W-1:0] rd_pin,
  output logic [DATA_W-1:0] rd_bal,
  input  logic              wr_en,
  input  logic [3:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_pin,
  input  logic [DATA_W-1:0] wr_bal
);

  logic [DATA_W-1:0] pin_mem [1:NUM_ACCOUNTS];
  logic [DATA_W-1:0] bal_mem [1:NUM_ACCOUNTS];

  // Unmapped addresses read as zero rather than indexing out of range.
  always_comb begin
    rd_pin = '0;
    rd_bal = '0;
    for (int i = 1; i <= NUM_ACCOUNTS; i++) begin
      if (rd_addr == 4'(i)) begin
        rd_pin = pin_mem[i];
        rd_bal = bal_mem[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i <= NUM_ACCOUNTS; i++) begin
        pin_mem[i] <= default_pin(i);
        bal_mem[i] <= DATA_W'(INIT_BALANCE);
      end
    end else if (wr_en) begin
      for (int i = 1; i <= NUM_ACCOUNTS; i++) begin
        if (wr_addr == 4'(i)) begin
          pin_mem[i] <= wr_pin;
          bal_mem[i] <= wr_bal;
        end
      end
    end
  end

endmodule

// File: rtl/atm_controller.sv
// ATM transaction engine: authenticates every cycle, executes one op, registers the result.
module atm_controller
  import atm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        operation,
  input  logic [3:0]        acc_num,
  input  logic [DATA_W-1:0] pin,
  input  logic [DATA_W-1:0] newPin,
  input  logic [DATA_W-1:0] amount,
  input  logic              language,
  output logic [DATA_W-1:0] balance,
  output logic              success,
  output logic [2:0]        state
);

  logic [DATA_W-1:0] rd_pin, rd_bal;
  logic              wr_en;
  logic [DATA_W-1:0] wr_pin, wr_bal;
  logic              acc_ok, auth;
  logic [DATA_W:0]   dep_sum;
  logic [DATA_W-1:0] nxt_bal;
  logic              nxt_succ;
  atm_state_t        nxt_state;
  logic [DATA_W-1:0] bal_p1;
  logic              succ_p1;
  atm_state_t        state_p1;
  logic              lang_unused_p1;

  function automatic logic fits_data(input logic [DATA_W:0] s);
    fits_data = ~s[DATA_W];
  endfunction

  atm_account_bank u_bank (
    .clk     (clk),
    .rst     (rst),
    .rd_addr (acc_num),
    .rd_pin  (rd_pin),
    .rd_bal  (rd_bal),
    .wr_en   (wr_en),
    .wr_addr (acc_num),
    .wr_pin  (wr_pin),
    .wr_bal  (wr_bal)
  );

  assign acc_ok  = (acc_num != 4'd0) && (acc_num <= 4'(NUM_ACCOUNTS));
  assign auth    = acc_ok && (pin == rd_pin);
  assign dep_sum = {1'b0, rd_bal} + {1'b0, amount};

  // Any rejected path falls through to the ERROR defaults with no write.
  always_comb begin
    nxt_state = ST_ERROR;
    nxt_succ  = 1'b0;
    nxt_bal   = '0;
    wr_en     = 1'b0;
    wr_pin    = rd_pin;
    wr_bal    = rd_bal;
    case (operation)
      OP_NOP: nxt_state = ST_IDLE;
      OP_EXIT: begin
        nxt_state = ST_EXIT;
        nxt_succ  = 1'b1;
      end
      OP_BALANCE: if (auth) begin
        nxt_state = ST_BALANCE;
        nxt_succ  = 1'b1;
        nxt_bal   = rd_bal;
      end
      OP_DEPOSIT: if (auth && fits_data(dep_sum)) begin
        nxt_state = ST_DEPOSIT;
        nxt_succ  = 1'b1;
        nxt_bal   = dep_sum[DATA_W-1:0];
        wr_en     = 1'b1;
        wr_bal    = dep_sum[DATA_W-1:0];
      end
      OP_WITHDRAW: if (auth && (amount <= rd_bal)) begin
        nxt_state = ST_WITHDRAW;
        nxt_succ  = 1'b1;
        nxt_bal   = rd_bal - amount;
        wr_en     = 1'b1;
        wr_bal    = rd_bal - amount;
      end
      OP_CHANGE_PIN: if (auth) begin
        nxt_state = ST_CHANGE_PIN;
        nxt_succ  = 1'b1;
        nxt_bal   = rd_bal;
        wr_en     = 1'b1;
        wr_pin    = newPin;
      end
      default: ;
    endcase
  end

  // Stage p1: registered transaction result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bal_p1         <= '0;
      succ_p1        <= 1'b0;
      state_p1       <= ST_IDLE;
      lang_unused_p1 <= 1'b0;
    end else begin
      bal_p1         <= nxt_bal;
      succ_p1        <= nxt_succ;
      state_p1       <= nxt_state;
      lang_unused_p1 <= language;
    end
  end

  assign balance = bal_p1;
  assign success = succ_p1;
  assign state   = state_p1;

endmodule

// File: tb/tb_atm_controller.sv
// Directed bench for atm_controller with a per-cycle account-table model and literal spot checks.
module tb_atm_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  operation = '0;
  logic [3:0]  acc_num = '0;
  logic [15:0] pin = '0, newPin = '0, amount = '0;
  logic        language = 1'b0;
  logic [15:0] balance;
  logic        success;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  int          m_bal [1:10];
  logic [15:0] m_pin [1:10];
  int          exp_bal = 0;
  int          exp_succ = 0;
  int          exp_state = 0;
  bit          model_live = 1'b0;

  atm_controller dut (
    .clk       (clk),
    .rst       (rst),
    .operation (operation),
    .acc_num   (acc_num),
    .pin       (pin),
    .newPin    (newPin),
    .amount    (amount),
    .language  (language),
    .balance   (balance),
    .success   (success),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    int defaults [10] = '{1234, 2345, 3456, 4567, 5678, 6789, 7890, 8901, 9012, 7123};
    for (int i = 1; i <= 10; i++) begin
      m_bal[i] = 1000;
      m_pin[i] = 16'(defaults[i-1]);
    end
    exp_bal = 0; exp_succ = 0; exp_state = 0;
  endtask

  // Outcome of one transaction from the account rules, applied at the clock edge.
  task automatic model_step();
    int a, amt, s;
    bit ok;
    a   = int'(acc_num);
    amt = int'(amount);
    ok  = (a >= 1) && (a <= 10) && (pin == m_pin[(a >= 1 && a <= 10) ? a : 1]);
    exp_bal = 0; exp_succ = 0; exp_state = 7;
    if (operation == 3'd0) exp_state = 0;
    else if (operation == 3'd4) begin exp_state = 4; exp_succ = 1; end
    else if (ok && operation == 3'd3) begin
      exp_state = 3; exp_succ = 1; exp_bal = m_bal[a];
    end else if (ok && operation == 3'd5) begin
      s = m_bal[a] + amt;
      if (s <= 65535) begin m_bal[a] = s; exp_state = 5; exp_succ = 1; exp_bal = s; end
    end else if (ok && operation == 3'd1) begin
      if (amt <= m_bal[a]) begin
        m_bal[a] -= amt; exp_state = 1; exp_succ = 1; exp_bal = m_bal[a];
      end
    end else if (ok && operation == 3'd2) begin
      m_pin[a] = newPin; exp_state = 2; exp_succ = 1; exp_bal = m_bal[a];
    end
  endtask

  always @(negedge clk) begin
    if (model_live && !rst) begin
      chk("model_balance", int'(balance), exp_bal);
      chk("model_success", int'(success), exp_succ);
      chk("model_state", int'(state), exp_state);
    end
  end

  task automatic run_op(input logic [2:0] op, input logic [3:0] a, input logic [15:0] p,
                        input logic [15:0] np, input logic [15:0] amt);
    @(negedge clk);
    operation = op; acc_num = a; pin = p; newPin = np; amount = amt;
    language = ~language;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic expect_out(input string name, input int b, input int s, input int st);
    chk({name, "_balance"}, int'(balance), b);
    chk({name, "_success"}, int'(success), s);
    chk({name, "_state"}, int'(state), st);
  endtask

  initial begin
    int pins [10] = '{1234, 2345, 3456, 4567, 5678, 6789, 7890, 8901, 9012, 7123};
    model_reset();
    repeat (2) @(negedge clk);
    expect_out("reset", 0, 0, 0);
    rst = 1'b0;
    model_live = 1'b1;

    for (int i = 1; i <= 10; i++) begin
      run_op(3'd3, 4'(i), 16'(pins[i-1]), 16'd0, 16'd0);
      expect_out($sformatf("inq_acc%0d", i), 1000, 1, 3);
    end

    run_op(3'd5, 4'd1, 16'd1234, 16'd0, 16'd1000);
    expect_out("dep1000", 2000, 1, 5);
    run_op(3'd1, 4'd1, 16'd1234, 16'd0, 16'd2500);
    expect_out("wd_over", 0, 0, 7);
    run_op(3'd3, 4'd1, 16'd1234, 16'd0, 16'd0);
    expect_out("after_reject", 2000, 1, 3);
    run_op(3'd1, 4'd1, 16'd1234, 16'd0, 16'd2000);
    expect_out("wd_all", 0, 1, 1);

    run_op(3'd3, 4'd2, 16'd1111, 16'd0, 16'd0);
    expect_out("bad_pin", 0, 0, 7);
    run_op(3'd3, 4'd11, 16'd0, 16'd0, 16'd0);
    expect_out("bad_acc", 0, 0, 7);
    run_op(3'd3, 4'd0, 16'd0, 16'd0, 16'd0);
    expect_out("acc_zero", 0, 0, 7);

    run_op(3'd2, 4'd3, 16'd3456, 16'd4242, 16'd0);
    expect_out("chg_pin", 1000, 1, 2);
    run_op(3'd3, 4'd3, 16'd3456, 16'd0, 16'd0);
    expect_out("old_pin", 0, 0, 7);
    run_op(3'd3, 4'd3, 16'd4242, 16'd0, 16'd0);
    expect_out("new_pin", 1000, 1, 3);

    run_op(3'd5, 4'd4, 16'd4567, 16'd0, 16'd65000);
    expect_out("dep_ovf", 0, 0, 7);
    run_op(3'd5, 4'd4, 16'd4567, 16'd0, 16'd64535);
    expect_out("dep_max", 65535, 1, 5);
    run_op(3'd4, 4'd4, 16'd0, 16'd0, 16'd0);
    expect_out("exit", 0, 1, 4);

    run_op(3'd5, 4'd5, 16'd5678, 16'd0, 16'd0);
    expect_out("dep_zero", 1000, 1, 5);
    run_op(3'd1, 4'd5, 16'd5678, 16'd0, 16'd0);
    expect_out("wd_zero", 1000, 1, 1);
    run_op(3'd1, 4'd6, 16'd6789, 16'd0, 16'd1);
    expect_out("wd_one", 999, 1, 1);
    run_op(3'd6, 4'd5, 16'd5678, 16'd0, 16'd0);
    expect_out("op6", 0, 0, 7);
    run_op(3'd7, 4'd5, 16'd5678, 16'd0, 16'd0);
    expect_out("op7", 0, 0, 7);
    run_op(3'd0, 4'd5, 16'd5678, 16'd0, 16'd0);
    expect_out("nop", 0, 0, 0);
    run_op(3'd3, 4'd7, 16'd7890, 16'd0, 16'd0);
    expect_out("untouched", 1000, 1, 3);

    // Mid-cycle reset with a deposit pending: the deposit must be discarded.
    @(negedge clk);
    operation = 3'd5; acc_num = 4'd6; pin = 16'd6789; amount = 16'd500;
    #2 rst = 1'b1;
    #1;
    model_reset();
    expect_out("async_rst", 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    operation = 3'd0;
    rst = 1'b0;

    run_op(3'd3, 4'd1, 16'd1234, 16'd0, 16'd0);
    expect_out("rst_bal1", 1000, 1, 3);
    run_op(3'd3, 4'd6, 16'd6789, 16'd0, 16'd0);
    expect_out("rst_bal6", 1000, 1, 3);
    run_op(3'd3, 4'd3, 16'd3456, 16'd0, 16'd0);
    expect_out("rst_pin3", 1000, 1, 3);
    run_op(3'd3, 4'd4, 16'd4567, 16'd0, 16'd0);
    expect_out("rst_bal4", 1000, 1, 3);
    run_op(3'd0, 4'd0, 16'd0, 16'd0, 16'd0);

    @(negedge clk);
    model_live = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
